compound_arbiter: RTL
=====================

COMPOUND_ARBITER -- requirements
Module: compound_arbiter

Interface
REQ-001 SHALL have parameter X_W, default 32, width of CompoundType field x.
REQ-002 SHALL have parameter CNT_W, default 16, width of the transfer counter.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port b_in0, input, CompoundType {mode: 1 bit, read=0/write=1; x: X_W signed; y: 1 bit}, requester 0 data.
REQ-006 SHALL have port b_in0_sync, input, 1, requester 0 offers data.
REQ-007 SHALL have port b_in0_notify, output, 1, arbiter ready to accept from requester 0.
REQ-008 SHALL have ports b_in1, b_in1_sync and b_in1_notify, identical to REQ-005..007, for requester 1.
REQ-009 SHALL have port b_out, output, CompoundType, forwarded data.
REQ-010 SHALL have port b_out_src, output, 1, index of the requester that supplied b_out.
REQ-011 SHALL have port b_out_sync, input, 1, consumer accepts data.
REQ-012 SHALL have port b_out_notify, output, 1, b_out valid.
REQ-013 SHALL have port xfer_cnt, output, CNT_W, count of completed output transfers.

Function
REQ-014 SHALL complete a transfer on any port only in a cycle where that port's sync and notify are both 1.
REQ-015 SHALL drive all notify outputs and b_out, b_out_src and xfer_cnt from registers; no combinational sync-to-notify path.
REQ-016 SHALL implement states READ and WRITE, plus a 1-bit grant pointer gnt.
REQ-017 In READ, SHALL assert exactly b_in<gnt>_notify; the other input notify and b_out_notify SHALL be 0.
REQ-018 In READ, on transfer from requester gnt, SHALL latch b_in<gnt> into b_out, set b_out_src=gnt, toggle gnt, and enter WRITE next cycle.
REQ-019 In READ, if b_in<gnt>_sync=0 and the other requester's sync=1, SHALL toggle gnt next cycle and stay in READ; no transfer occurs that cycle.
REQ-020 In READ, if neither sync is 1, SHALL hold gnt and state.
REQ-021 In WRITE, SHALL assert b_out_notify=1 and both input notifies=0; b_out and b_out_src SHALL be stable.
REQ-022 In WRITE, on b_out_sync=1, SHALL increment xfer_cnt modulo 2^CNT_W, wrapping from all-ones to 0, and return to READ next cycle.
REQ-023 Latency: input accepted in cycle t gives b_out_notify=1 in cycle t+1; output accepted in cycle t gives b_in<gnt>_notify=1 in cycle t+1.
REQ-024 Fairness: after serving requester k, SHALL offer requester 1-k first; with both syncs held at 1, grants SHALL alternate 0,1,0,1.
REQ-025 SHALL forward b_out with mode, x and y bit-exact from the accepted input.
REQ-026 SHALL hold all state while syncs are 0; syncs asserted against a 0 notify have no effect.

Reset
REQ-027 On rst=1, SHALL immediately set state=READ, gnt=0, b_in0_notify=1, b_in1_notify=0, b_out_notify=0, b_out={read,0,0}, b_out_src=0, xfer_cnt=0.
REQ-028 Reset mid-transfer, in either state, SHALL discard held data; the first transfer after release SHALL be offered to requester 0.

Verification
REQ-029 Reset release, no syncs -> b_in0_notify=1, b_in1_notify=0, b_out_notify=0, xfer_cnt=0 held indefinitely.
REQ-030 b_in0={write,5,1} with sync0=1 at cycle t; b_out_sync=1 at t+1 -> b_out={write,5,1}, src=0, notify at t+1; xfer_cnt=1 at t+2; b_in1_notify=1 at t+2.
REQ-031 Both syncs held at 1, b_out_sync held at 1 -> b_out_src sequence 0,1,0,1; one output every 2 cycles.
REQ-032 Only sync1=1 after reset -> gnt flips at t+1; b_in1_notify=1 at t+1; transfer at t+1; b_out_src=1 at t+2.
REQ-033 CNT_W=2, 5 transfers -> xfer_cnt sequence 1,2,3,0,1.
REQ-034 rst pulsed while in WRITE with b_out_notify=1 -> b_out_notify=0 and b_out={read,0,0} immediately; b_in0_notify=1.

Source files
------------

// File: rtl/compound_arbiter.sv
// Two-requester round-robin arbiter forwarding a CompoundType word to one consumer.
// CompoundType is carried flat as {mode, x[X_W-1:0], y}; mode 0 = read, 1 = write.
module compound_arbiter #(
    parameter int X_W   = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [X_W+1:0]   b_in0,
    input  logic             b_in0_sync,
    output logic             b_in0_notify,
    input  logic [X_W+1:0]   b_in1,
    input  logic             b_in1_sync,
    output logic             b_in1_notify,
    output logic [X_W+1:0]   b_out,
    output logic             b_out_src,
    input  logic             b_out_sync,
    output logic             b_out_notify,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic {READ, WRITE} state_e;

    state_e           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic [X_W+1:0]   out_q, out_d;
    logic             src_q, src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             n0_q, n0_d;
    logic             n1_q, n1_d;
    logic             no_q, no_d;

    logic [X_W+1:0]   sel_data;
    logic             sel_sync;
    logic             oth_sync;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        out_d    = out_q;
        src_d    = src_q;
        cnt_d    = cnt_q;
        sel_data = gnt_q ? b_in1 : b_in0;
        sel_sync = gnt_q ? b_in1_sync : b_in0_sync;
        oth_sync = gnt_q ? b_in0_sync : b_in1_sync;

        case (state_q)
            READ: begin
                if (sel_sync) begin
                    out_d   = sel_data;
                    src_d   = gnt_q;
                    gnt_d   = ~gnt_q;
                    state_d = WRITE;
                end else if (oth_sync) begin
                    // Idle granted side yields to a waiting requester; it is served next cycle.
                    gnt_d = ~gnt_q;
                end
            end
            WRITE: begin
                if (b_out_sync) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = READ;
                end
            end
        endcase

        // Notifies are registered copies of the next-state decode, so no sync reaches a notify combinationally.
        n0_d = (state_d == READ) && !gnt_d;
        n1_d = (state_d == READ) &&  gnt_d;
        no_d = (state_d == WRITE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= READ;
            gnt_q   <= 1'b0;
            out_q   <= '0;
            src_q   <= 1'b0;
            cnt_q   <= '0;
            n0_q    <= 1'b1;
            n1_q    <= 1'b0;
            no_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            out_q   <= out_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            n0_q    <= n0_d;
            n1_q    <= n1_d;
            no_q    <= no_d;
        end
    end

    assign b_in0_notify = n0_q;
    assign b_in1_notify = n1_q;
    assign b_out_notify = no_q;
    assign b_out        = out_q;
    assign b_out_src    = src_q;
    assign xfer_cnt     = cnt_q;

endmodule
